bp_fe_bp_update_queue: RTL and testbench
========================================

Name: bp_fe_bp_update_queue

Overview:
- In-order tracking queue for in-flight conditional branch predictions; sits directly upstream of the branch predictor wrapper's write port.
- Records the BHT index and predicted direction for each prediction made at fetch.
- When the backend resolves the oldest branch, emits a one-cycle registered update (w_v/idx_w/correct) that drives the predictor's w_v_i, idx_w_i and correct_i.
- Flush discards all outstanding entries on redirect.

Parameters:
bht_idx_width_p, "inv", BHT index width; must match the predictor instance.
els_p, 4, queue depth; power of 2, >= 2.
ptr_width_lp (localparam), log2(els_p), read/write pointer width.

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous, active-high reset
pred_v_i  in  1  new prediction valid; accepted when pred_v_i & pred_ready_o
pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction
pred_taken_i  in  1  predicted direction (1 = taken)
pred_ready_o  out  1  queue can accept a prediction this cycle
res_v_i  in  1  oldest outstanding branch resolved this cycle
res_taken_i  in  1  actual resolved direction
flush_i  in  1  discard all outstanding entries
w_v_o  out  1  predictor update valid, to predictor w_v_i
idx_w_o  out  bht_idx_width_p  update index, to predictor idx_w_i
correct_o  out  1  prediction matched outcome, to predictor correct_i
count_o  out  ptr_width_lp+1  number of occupied entries

Behaviour:
- Storage: els_p entries of {idx, taken}. Write pointer wptr, read pointer rptr, occupancy count (0..els_p). Pointers wrap modulo els_p.
- Reset (reset_i=1 at clock edge):
  - wptr=rptr=0, count=0.
  - w_v_o=0, idx_w_o=0, correct_o=0.
  - Entry contents are don't-care.
  - pred_ready_o is forced 0 while reset_i=1.
  - Reset overrides flush, alloc and resolve in the same cycle. Reset mid-operation drops all entries with no update emitted.
- pred_ready_o = ~reset_i & (count != els_p). Combinational; does not depend on res_v_i (no full-bypass).
- Alloc (pred_v_i & pred_ready_o & ~flush_i): write {pred_idx_i, pred_taken_i} at wptr; wptr+1.
- Resolve (res_v_i & count != 0):
  - Read entry at rptr; rptr+1.
  - Next cycle: w_v_o=1, idx_w_o=entry.idx, correct_o=(entry.taken == res_taken_i).
  - Latency: exactly 1 cycle from res_v_i to w_v_o.
  - w_v_o is a 1-cycle pulse per resolve. Back-to-back resolves give back-to-back pulses.
- Resolve while empty (count=0):
  - Ignored; w_v_o=0 next cycle, state unchanged.
  - No bypass from a same-cycle alloc.
- When no resolve occurs: w_v_o=0 next cycle; idx_w_o/correct_o hold their previous values.
- Count next = count + alloc - resolve. Simultaneous alloc and resolve with 0 < count < els_p leaves count unchanged.
- Full (count=els_p) with res_v_i and pred_v_i: resolve proceeds, alloc rejected (ready was 0). Count becomes els_p-1.
- Flush:
  - A same-cycle resolve is processed first, and its update is emitted next cycle.
  - Then rptr=wptr, count=0.
  - A same-cycle alloc is dropped.
  - After flush, pred_ready_o=1 the next cycle.
- count_o reflects registered count. Wrap of wptr/rptr past els_p-1 to 0 is transparent to ordering.

Test Plan:
- Reset then idle: assert reset_i 2 cycles -> w_v_o=0, idx_w_o=0, correct_o=0, count_o=0, pred_ready_o=0 during reset and 1 after.
- Single path (bht_idx_width_p=9): alloc idx=0x1A5, taken=1; 3 cycles later res_v_i=1, res_taken_i=0 -> next cycle w_v_o=1, idx_w_o=0x1A5, correct_o=0, count_o 1->0.
- Fill/wrap: alloc idx 1,2,3,4 -> pred_ready_o=0, count_o=4. Resolve all taken (entries taken=1) while allocating 5,6 -> updates in order 1,2,3,4 with correct_o=1, then 5,6; pointers wrap with no reorder.
- Full plus simultaneous events: count=4, pred_v_i=1 and res_v_i=1 same cycle -> oldest resolved, new entry not written, count_o=3.
- Flush with resolve: count=3 (idx 7,8,9), flush_i=1, res_v_i=1, pred_v_i=1 (idx 10) -> one update idx_w_o=7, count_o=0, subsequent res_v_i produces no w_v_o.
- Empty resolve plus alloc: count=0, res_v_i=1, pred_v_i=1 idx=0x55 -> w_v_o=0 next cycle, count_o=1; next res_v_i yields idx_w_o=0x55.

Source files
------------

// File: rtl/bp_fe_bp_update_queue.sv
// In-order tracking queue for in-flight conditional branch predictions.
// Each prediction made at fetch records its BHT index and predicted direction.
// When the backend resolves the oldest branch, a registered one-cycle update
// (w_v/idx_w/correct) is produced for the branch predictor's write port.
// A flush discards every outstanding entry on redirect.
module bp_fe_bp_update_queue #(
  parameter int bht_idx_width_p = 9,
  parameter int els_p           = 4,
  localparam int ptr_width_lp   = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp:0]      count_o
);

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [ptr_width_lp:0]   cnt_t;

  localparam ptr_t ptr_one_lp   = ptr_t'(1);
  localparam cnt_t cnt_full_lp  = cnt_t'(els_p);

  logic [bht_idx_width_p-1:0] idx_mem [els_p];
  logic [els_p-1:0]           taken_mem;

  ptr_t wptr;
  ptr_t rptr;
  cnt_t count;

  logic alloc;
  logic resolve;

  // Ready never looks at res_v_i: a full queue rejects allocs even when the
  // oldest entry resolves in the same cycle.
  assign pred_ready_o = ~reset_i & (count != cnt_full_lp);

  // A flush drops a same-cycle alloc; a resolve only counts when an entry exists.
  assign alloc   = pred_v_i & pred_ready_o & ~flush_i;
  assign resolve = res_v_i & (count != '0);

  assign count_o = count;

  // Entry storage; contents are don't-care until allocated, so no reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      idx_mem[wptr]   <= pred_idx_i;
      taken_mem[wptr] <= pred_taken_i;
    end
  end

  // Pointer and occupancy tracking; a flush snaps the read side onto the write side.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        wptr <= wptr + ptr_one_lp;
      end
      if (flush_i) begin
        rptr  <= wptr;
        count <= '0;
      end else begin
        if (resolve) begin
          rptr <= rptr + ptr_one_lp;
        end
        count <= count + cnt_t'(alloc) - cnt_t'(resolve);
      end
    end
  end

  // Registered predictor update; index and correctness hold between pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
    end else begin
      w_v_o <= resolve;
      if (resolve) begin
        idx_w_o   <= idx_mem[rptr];
        correct_o <= taken_mem[rptr] ~^ res_taken_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Self-checking bench for bp_fe_bp_update_queue: a table of per-cycle
// stimulus rows with hand-derived expected outputs, plus a scoreboard queue
// of expected predictor updates popped whenever the DUT pulses w_v_o.
module tb_bp_fe_bp_update_queue;

  localparam int idx_w = 9;

  typedef struct {
    bit               rst;
    bit               pv;
    logic [idx_w-1:0] pidx;
    bit               pt;
    bit               rv;
    bit               rt;
    bit               fl;
    bit               exp_ready;
    bit               exp_upd;
    logic [idx_w-1:0] exp_idx;
    bit               exp_corr;
    int               exp_cnt;
  } vec_t;

  typedef struct {
    logic [idx_w-1:0] idx;
    logic             correct;
  } upd_t;

  logic             clk;
  logic             reset;
  logic             pred_v;
  logic [idx_w-1:0] pred_idx;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_v;
  logic             res_taken;
  logic             flush;
  logic             w_v;
  logic [idx_w-1:0] idx_w_out;
  logic             correct;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;

  upd_t             sb[$];
  vec_t             tbl[$];
  logic [idx_w-1:0] last_idx;
  logic             last_corr;

  bp_fe_bp_update_queue #(
    .bht_idx_width_p(idx_w),
    .els_p          (4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .pred_v_i    (pred_v),
    .pred_idx_i  (pred_idx),
    .pred_taken_i(pred_taken),
    .pred_ready_o(pred_ready),
    .res_v_i     (res_v),
    .res_taken_i (res_taken),
    .flush_i     (flush),
    .w_v_o       (w_v),
    .idx_w_o     (idx_w_out),
    .correct_o   (correct),
    .count_o     (count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input bit rst, input bit pv, input logic [idx_w-1:0] pidx,
                              input bit pt, input bit rv, input bit rt, input bit fl,
                              input bit er, input bit eu, input logic [idx_w-1:0] ei,
                              input bit ec, input int ecnt);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pidx = pidx; v.pt = pt;
    v.rv = rv; v.rt = rt; v.fl = fl;
    v.exp_ready = er; v.exp_upd = eu; v.exp_idx = ei; v.exp_corr = ec; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one row at the falling edge, check ready before the rising edge,
  // then check the registered outputs just after it.
  task automatic apply_stimulus(input vec_t v, input int row);
    upd_t u;
    @(negedge clk);
    reset      = v.rst;
    pred_v     = v.pv;
    pred_idx   = v.pidx;
    pred_taken = v.pt;
    res_v      = v.rv;
    res_taken  = v.rt;
    flush      = v.fl;
    #1;
    check_output($sformatf("r%0d_ready", row), 32'(pred_ready), 32'(v.exp_ready));
    @(posedge clk);
    if (v.exp_upd) begin
      u.idx     = v.exp_idx;
      u.correct = v.exp_corr;
      sb.push_back(u);
    end
    if (v.rst) begin
      last_idx  = '0;
      last_corr = 1'b0;
    end
    #1;
    check_output($sformatf("r%0d_w_v", row), 32'(w_v), 32'(v.exp_upd));
    if (w_v === 1'b1) begin
      check_output($sformatf("r%0d_sb_nonempty", row), 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        u = sb.pop_front();
        last_idx  = u.idx;
        last_corr = u.correct;
      end
    end
    check_output($sformatf("r%0d_idx_w", row), 32'(idx_w_out), 32'(last_idx));
    check_output($sformatf("r%0d_correct", row), 32'(correct), 32'(last_corr));
    check_output($sformatf("r%0d_count", row), 32'(count), 32'(v.exp_cnt));
  endtask

  // Main sequence: table rows first, then hand-written corner sequences.
  initial begin
    reset = 1'b1; pred_v = 1'b0; pred_idx = '0; pred_taken = 1'b0;
    res_v = 1'b0; res_taken = 1'b0; flush = 1'b0;
    last_idx = '0; last_corr = 1'b0;

    //               rst pv pidx    pt rv rt fl  rdy upd idx   cor cnt
    // reset then idle
    tbl.push_back(mk(1, 0, 9'h000, 0, 0, 0, 0,  0, 0, 9'h000, 0, 0));
    tbl.push_back(mk(1, 0, 9'h000, 0, 0, 0, 0,  0, 0, 9'h000, 0, 0));
    tbl.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 0));
    // single path: taken predicted, not-taken resolved
    tbl.push_back(mk(0, 1, 9'h1A5, 1, 0, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 0,  1, 1, 9'h1A5, 0, 0));
    tbl.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 0));
    // fill to full (pointers start at 1, so they wrap)
    tbl.push_back(mk(0, 1, 9'h001, 1, 0, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 1, 9'h002, 1, 0, 0, 0,  1, 0, 9'h000, 0, 2));
    tbl.push_back(mk(0, 1, 9'h003, 1, 0, 0, 0,  1, 0, 9'h000, 0, 3));
    tbl.push_back(mk(0, 1, 9'h004, 1, 0, 0, 0,  1, 0, 9'h000, 0, 4));
    // full: alloc rejected
    tbl.push_back(mk(0, 1, 9'h0EE, 1, 0, 0, 0,  0, 0, 9'h000, 0, 4));
    // full with alloc and resolve: resolve only
    tbl.push_back(mk(0, 1, 9'h005, 1, 1, 1, 0,  0, 1, 9'h001, 1, 3));
    // back-to-back resolves while allocating 5,6
    tbl.push_back(mk(0, 1, 9'h005, 1, 1, 1, 0,  1, 1, 9'h002, 1, 3));
    tbl.push_back(mk(0, 1, 9'h006, 0, 1, 1, 0,  1, 1, 9'h003, 1, 3));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 1, 0,  1, 1, 9'h004, 1, 2));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 0,  1, 1, 9'h005, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 0,  1, 1, 9'h006, 1, 0));
    // flush with same-cycle resolve and alloc
    tbl.push_back(mk(0, 1, 9'h007, 1, 0, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 1, 9'h008, 0, 0, 0, 0,  1, 0, 9'h000, 0, 2));
    tbl.push_back(mk(0, 1, 9'h009, 1, 0, 0, 0,  1, 0, 9'h000, 0, 3));
    tbl.push_back(mk(0, 1, 9'h00A, 1, 1, 1, 1,  1, 1, 9'h007, 1, 0));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 1, 0,  1, 0, 9'h000, 0, 0));
    // empty resolve plus alloc: no bypass
    tbl.push_back(mk(0, 1, 9'h055, 0, 1, 0, 0,  1, 0, 9'h000, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 0, 1, 0, 0,  1, 1, 9'h055, 1, 0));
    tbl.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i], i);
    end

    // Reset mid-operation drops entries and suppresses a same-cycle resolve.
    apply_stimulus(mk(0, 1, 9'h100, 1, 0, 0, 0,  1, 0, 9'h000, 0, 1), 100);
    apply_stimulus(mk(0, 1, 9'h101, 0, 0, 0, 0,  1, 0, 9'h000, 0, 2), 101);
    apply_stimulus(mk(1, 1, 9'h102, 1, 1, 1, 0,  0, 0, 9'h000, 0, 0), 102);
    apply_stimulus(mk(0, 0, 9'h000, 0, 1, 1, 0,  1, 0, 9'h000, 0, 0), 103);

    // Flush while empty drops the alloc; a later resolve finds nothing.
    apply_stimulus(mk(0, 1, 9'h033, 1, 0, 0, 1,  1, 0, 9'h000, 0, 0), 104);
    apply_stimulus(mk(0, 0, 9'h000, 0, 1, 1, 0,  1, 0, 9'h000, 0, 0), 105);

    // Entry written after a flush is the one resolved next.
    apply_stimulus(mk(0, 1, 9'h1FF, 0, 0, 0, 0,  1, 0, 9'h000, 0, 1), 106);
    apply_stimulus(mk(0, 0, 9'h000, 0, 1, 1, 0,  1, 1, 9'h1FF, 0, 0), 107);
    apply_stimulus(mk(0, 0, 9'h000, 0, 0, 0, 0,  1, 0, 9'h000, 0, 0), 108);

    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
